// File: rtl/ov_capture_if.sv
// rtl/ov_capture_if.sv - pixel word stream between ov_capture and the frame-store writer
//
// pix_data  [15:0]  pixel word, first camera byte in [15:8]
// pix_sof           word is the first pixel of a frame
// pix_eol           word is the last pixel of a line
// pix_valid         a word is presented
// pix_ready         consumer accepts; transfer when pix_valid & pix_ready
interface ov_capture_if;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_valid;
    logic        pix_ready;

    modport master (output pix_data, output pix_sof, output pix_eol, output pix_valid,
                    input  pix_ready);
    modport slave  (input  pix_data, input  pix_sof, input  pix_eol, input  pix_valid,
                    output pix_ready);
endinterface

// File: rtl/ov_capture.sv
// rtl/ov_capture.sv - OV camera pixel capture: oversampling, RGB565 pairing, framing, FIFO
//
// Ports:
//  clk_sys, rst_n        system clock, asynchronous active-low reset
//  ov_vsync/ov_href      camera sync inputs (async, oversampled)
//  ov_pclk/ov_data       camera pixel clock and byte (async, oversampled; pclk <= clk_sys/4)
//  cap_en                level: continuous capture
//  cap_single            pulse: capture one frame
//  clr_ovf               pulse: clear stu_ovf
//  pix                   pixel stream out (master side of ov_capture_if)
//  stu_busy              capture FSM not idle
//  stu_ovf               sticky: a pixel was dropped on a full FIFO
//  stu_pix_cnt           pixels in the last completed line (saturating)
//  stu_line_cnt          lines in the last completed frame (saturating)
//  stu_frame_cnt         completed frames (wrapping)
module ov_capture #(
    parameter int FIFO_AW = 4,
    parameter int VS_FILT = 8
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic         ov_vsync,
    input  logic         ov_href,
    input  logic         ov_pclk,
    input  logic [7:0]   ov_data,
    input  logic         cap_en,
    input  logic         cap_single,
    input  logic         clr_ovf,
    ov_capture_if.master pix,
    output logic         stu_busy,
    output logic         stu_ovf,
    output logic [10:0]  stu_pix_cnt,
    output logic [10:0]  stu_line_cnt,
    output logic [15:0]  stu_frame_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_WAIT_FRM,
        ST_CAPTURE
    } state_t;

    state_t state, state_nxt;

    // Input synchronisers. pclk/href/data travel through identical stages so
    // that the byte sampled at the strobe is the one present at the pclk rise.
    logic               pclk_s1, pclk_d1, pclk_d2;
    logic               href_s1, href_d1, href_d2;
    logic [7:0]         data_s1, data_d1;
    logic               vs_s1, vs_s2;
    logic [VS_FILT-1:0] vs_sr;
    logic               vs_f, vs_f_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pclk_s1 <= 1'b0;
            pclk_d1 <= 1'b0;
            pclk_d2 <= 1'b0;
            href_s1 <= 1'b0;
            href_d1 <= 1'b0;
            href_d2 <= 1'b0;
            data_s1 <= '0;
            data_d1 <= '0;
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            vs_sr   <= '0;
            vs_f    <= 1'b0;
            vs_f_q  <= 1'b0;
        end else begin
            pclk_s1 <= ov_pclk;
            pclk_d1 <= pclk_s1;
            pclk_d2 <= pclk_d1;
            href_s1 <= ov_href;
            href_d1 <= href_s1;
            href_d2 <= href_d1;
            data_s1 <= ov_data;
            data_d1 <= data_s1;
            vs_s1   <= ov_vsync;
            vs_s2   <= vs_s1;
            vs_sr   <= {vs_sr[VS_FILT-2:0], vs_s2};
            // Glitch filter: switch only on a full window of agreeing samples.
            if (&vs_sr) begin
                vs_f <= 1'b1;
            end else if (~|vs_sr) begin
                vs_f <= 1'b0;
            end
            vs_f_q  <= vs_f;
        end
    end

    logic byte_in, href_fall, vs_rise, vs_fall;
    assign byte_in   = pclk_d1 & ~pclk_d2 & href_d1;
    assign href_fall = href_d2 & ~href_d1;
    assign vs_rise   = vs_f & ~vs_f_q;
    assign vs_fall   = ~vs_f & vs_f_q;

    // Capture FSM
    logic single_run;
    logic run_ok;
    assign run_ok = cap_en | single_run;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (cap_en || cap_single) state_nxt = ST_WAIT_VS;
            // Waiting for a full blanking interval guarantees we never start mid-frame.
            ST_WAIT_VS:  if (!run_ok) state_nxt = ST_IDLE;
                         else if (vs_f) state_nxt = ST_WAIT_FRM;
            ST_WAIT_FRM: if (!run_ok) state_nxt = ST_IDLE;
                         else if (vs_fall) state_nxt = ST_CAPTURE;
            ST_CAPTURE:  if (vs_rise) state_nxt = (cap_en && !single_run) ? ST_WAIT_FRM : ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    logic in_cap, cap_start, frm_end;
    assign in_cap    = (state == ST_CAPTURE);
    assign cap_start = (state == ST_WAIT_FRM) && (state_nxt == ST_CAPTURE);
    assign frm_end   = in_cap && vs_rise;
    assign stu_busy  = (state != ST_IDLE);

    // Byte pairing and pending pixel. The pending register delays each pixel
    // by one so that the line's last pixel can be tagged eol at href fall.
    logic        phase;
    logic [7:0]  hi_byte;
    logic [15:0] pend_data;
    logic        pend_vld;
    logic        sof_arm;
    logic [10:0] pix_in_line;
    logic [10:0] line_cnt;
    logic        wr_en, wr_eol;

    assign wr_en  = in_cap && pend_vld && ((byte_in && phase) || href_fall);
    assign wr_eol = href_fall;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            phase         <= 1'b0;
            hi_byte       <= '0;
            pend_data     <= '0;
            pend_vld      <= 1'b0;
            sof_arm       <= 1'b0;
            pix_in_line   <= '0;
            line_cnt      <= '0;
            single_run    <= 1'b0;
            stu_pix_cnt   <= '0;
            stu_line_cnt  <= '0;
            stu_frame_cnt <= '0;
        end else begin
            if (state == ST_IDLE) begin
                single_run <= cap_single;
            end
            if (wr_en) begin
                sof_arm <= 1'b0;
            end
            if (cap_start) begin
                sof_arm  <= 1'b1;
                line_cnt <= '0;
            end
            if (!in_cap) begin
                phase       <= 1'b0;
                pend_vld    <= 1'b0;
                pix_in_line <= '0;
            end else if (byte_in) begin
                if (!phase) begin
                    hi_byte <= data_d1;
                    phase   <= 1'b1;
                end else begin
                    pend_data <= {hi_byte, data_d1};
                    pend_vld  <= 1'b1;
                    phase     <= 1'b0;
                    if (pix_in_line != 11'h7FF) pix_in_line <= pix_in_line + 11'd1;
                end
            end else if (href_fall) begin
                phase       <= 1'b0;
                pix_in_line <= '0;
                if (pend_vld) begin
                    pend_vld    <= 1'b0;
                    stu_pix_cnt <= pix_in_line;
                    if (line_cnt != 11'h7FF) line_cnt <= line_cnt + 11'd1;
                end
            end
            if (frm_end) begin
                stu_line_cnt  <= line_cnt;
                stu_frame_cnt <= stu_frame_cnt + 16'd1;
            end
        end
    end

    // FIFO with a registered head. Full is sampled before any pop in the same
    // cycle, so a push against a full FIFO is dropped even while it drains.
    logic [17:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic             full, push, pop, head_vld;

    assign full       = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign push       = wr_en && !full;
    assign pop        = pix.pix_valid && pix.pix_ready;
    assign rd_ptr_nxt = rd_ptr + {{FIFO_AW{1'b0}}, pop};
    assign head_vld   = (wr_ptr != rd_ptr_nxt);

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {sof_arm, wr_eol, pend_data};
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pix.pix_valid <= 1'b0;
            pix.pix_sof   <= 1'b0;
            pix.pix_eol   <= 1'b0;
            pix.pix_data  <= '0;
            stu_ovf       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{FIFO_AW{1'b0}}, 1'b1};
            rd_ptr        <= rd_ptr_nxt;
            pix.pix_valid <= head_vld;
            {pix.pix_sof, pix.pix_eol, pix.pix_data} <= head_vld ? mem[rd_ptr_nxt[FIFO_AW-1:0]] : 18'h0;
            // A new drop wins over a simultaneous clear.
            stu_ovf       <= (wr_en && full) || (stu_ovf && !clr_ovf);
        end
    end

endmodule

// File: tb/tb_ov_capture.sv
// tb/tb_ov_capture.sv - randomized self-checking bench for ov_capture with a byte-level frame model
module tb_ov_capture;

    localparam int DEPTH = 16;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        ov_vsync, ov_href, ov_pclk;
    logic [7:0]  ov_data;
    logic        cap_en, cap_single, clr_ovf;
    logic        stu_busy, stu_ovf;
    logic [10:0] stu_pix_cnt, stu_line_cnt;
    logic [15:0] stu_frame_cnt;

    ov_capture_if pix();

    ov_capture #(.FIFO_AW(4), .VS_FILT(8)) dut (
        .clk_sys       (clk_sys),
        .rst_n         (rst_n),
        .ov_vsync      (ov_vsync),
        .ov_href       (ov_href),
        .ov_pclk       (ov_pclk),
        .ov_data       (ov_data),
        .cap_en        (cap_en),
        .cap_single    (cap_single),
        .clr_ovf       (clr_ovf),
        .pix           (pix),
        .stu_busy      (stu_busy),
        .stu_ovf       (stu_ovf),
        .stu_pix_cnt   (stu_pix_cnt),
        .stu_line_cnt  (stu_line_cnt),
        .stu_frame_cnt (stu_frame_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ready_mode = 2;
    logic [17:0] rx_q[$];
    logic [17:0] exp_q[$];
    logic [7:0]  frm_bytes[$];
    int          lens[$];
    int          exp_frames, exp_lines, exp_pix;
    bit          use_seq;
    logic [7:0]  seq_ctr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Consumer: choose ready for the coming edge, then log the transfer it implies.
    always @(negedge clk_sys) begin
        case (ready_mode)
            0:       pix.pix_ready = 1'b0;
            1:       pix.pix_ready = ($urandom_range(0, 3) != 0);
            default: pix.pix_ready = 1'b1;
        endcase
        if (rst_n === 1'b1 && pix.pix_valid === 1'b1 && pix.pix_ready)
            rx_q.push_back({pix.pix_sof, pix.pix_eol, pix.pix_data});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(pix.pix_valid), 32'd0);
        chk({tag, "_data"},  32'({pix.pix_sof, pix.pix_eol, pix.pix_data}), 32'd0);
        chk({tag, "_busy"},  32'(stu_busy), 32'd0);
        chk({tag, "_ovf"},   32'(stu_ovf), 32'd0);
        chk({tag, "_cnts"},  32'({stu_pix_cnt, stu_line_cnt}), 32'd0);
        chk({tag, "_frm"},   32'(stu_frame_cnt), 32'd0);
    endtask

    task automatic clear_model();
        rx_q.delete();
        exp_q.delete();
        exp_frames = 0;
        exp_lines  = 0;
        exp_pix    = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(3);
        chk_zero("reset");
        rst_n = 1'b1;
        clear_model();
        cyc(2);
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        cyc(3);
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic send_byte(input logic [7:0] b);
        ov_data = b;
        ov_pclk = 1'b0;
        cyc(2);
        ov_pclk = 1'b1;
        cyc(2);
    endtask

    // One camera frame: blanking, vsync fall, lines from lens[], blanking.
    task automatic send_frame(input int en_line, input int rst_line);
        logic [7:0] b;
        frm_bytes.delete();
        ov_vsync = 1'b1;
        cyc(30);
        ov_vsync = 1'b0;
        cyc(12);
        foreach (lens[l]) begin
            if (l == en_line) cap_en = 1'b1;
            ov_href = 1'b1;
            for (int i = 0; i < lens[l]; i++) begin
                if (use_seq) begin
                    b = seq_ctr;
                    seq_ctr = seq_ctr + 8'd1;
                end else begin
                    b = 8'($urandom);
                end
                frm_bytes.push_back(b);
                if (l == rst_line && i == 2) mid_reset();
                send_byte(b);
            end
            ov_href = 1'b0;
            ov_pclk = 1'b0;
            cyc(8);
        end
        ov_vsync = 1'b1;
        cyc(30);
    endtask

    // Reference: pixels are byte pairs per line, odd trailing byte ignored,
    // eol on a line's last pixel, sof on the frame's first pixel.
    task automatic model_frame();
        int  idx = 0;
        int  np;
        bit  first = 1'b1;
        exp_lines = 0;
        foreach (lens[l]) begin
            np = lens[l] / 2;
            if (np > 0) begin
                exp_lines++;
                exp_pix = np;
            end
            for (int k = 0; k < np; k++) begin
                exp_q.push_back({first, (k == np - 1), frm_bytes[idx + 2*k], frm_bytes[idx + 2*k + 1]});
                first = 1'b0;
            end
            idx += lens[l];
        end
        exp_frames++;
    endtask

    task automatic drain_and_compare(input string tag);
        int t = 0;
        while (rx_q.size() < exp_q.size() && t < 3000) begin
            cyc(1);
            t++;
        end
        cyc(20);
        chk({tag, "_nwords"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_status(input string tag, input bit busy_exp);
        chk({tag, "_frames"}, 32'(stu_frame_cnt), 32'(exp_frames));
        chk({tag, "_lines"},  32'(stu_line_cnt),  32'(exp_lines));
        chk({tag, "_pixcnt"}, 32'(stu_pix_cnt),   32'(exp_pix));
        chk({tag, "_busy"},   32'(stu_busy),      32'(busy_exp));
    endtask

    task automatic pulse_single();
        cap_single = 1'b1;
        cyc(1);
        cap_single = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ov_vsync = 1'b1; ov_href = 1'b0; ov_pclk = 1'b0; ov_data = '0;
        cap_en = 1'b0; cap_single = 1'b0; clr_ovf = 1'b0;
        use_seq = 1'b0; seq_ctr = 8'd1;
        clear_model();

        // 1: single frame, 4 lines x 6 bytes, incrementing data
        do_reset();
        ready_mode = 1;
        use_seq = 1'b1; seq_ctr = 8'h01;
        pulse_single();
        lens = '{6, 6, 6, 6};
        send_frame(-1, -1);
        model_frame();
        drain_and_compare("t1");
        chk_status("t1", 1'b0);

        // 2: continuous capture, 3 random frames with odd/empty lines
        do_reset();
        use_seq = 1'b0;
        cap_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            lens.delete();
            repeat ($urandom_range(2, 5)) lens.push_back(int'($urandom_range(0, 14)));
            lens.push_back(int'($urandom_range(2, 12)));
            send_frame(-1, -1);
            model_frame();
        end
        drain_and_compare("t2");
        chk_status("t2", 1'b1);
        chk("t2_ovf", 32'(stu_ovf), 32'd0);
        cap_en = 1'b0;
        cyc(4);
        chk("t2_idle", 32'(stu_busy), 32'd0);

        // 3: overflow with a stalled consumer
        do_reset();
        ready_mode = 0;
        pulse_single();
        lens = '{40};
        send_frame(-1, -1);
        model_frame();
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        chk("t3_ovf_set", 32'(stu_ovf), 32'd1);
        chk("t3_valid",   32'(pix.pix_valid), 32'd1);
        chk("t3_noxfer",  32'(rx_q.size()), 32'd0);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        chk("t3_ovf_clr", 32'(stu_ovf), 32'd0);
        ready_mode = 2;
        drain_and_compare("t3");
        chk_status("t3", 1'b0);

        // 4: odd-length line followed by an even one
        do_reset();
        ready_mode = 1;
        use_seq = 1'b1; seq_ctr = 8'h10;
        pulse_single();
        lens = '{7, 4};
        send_frame(-1, -1);
        model_frame();
        drain_and_compare("t4");
        chk_status("t4", 1'b0);

        // 5: vsync glitch in blanking, then cap_en raised mid-frame
        do_reset();
        use_seq = 1'b0;
        cap_en = 1'b1;
        cyc(30);
        ov_vsync = 1'b0;
        cyc(5);
        ov_vsync = 1'b1;
        cyc(30);
        chk("t5_glitch_frm", 32'(stu_frame_cnt), 32'd0);
        chk("t5_glitch_rx",  32'(rx_q.size()), 32'd0);
        cap_en = 1'b0;
        cyc(5);
        lens = '{4, 4, 4};
        send_frame(1, -1);
        lens = '{6, 6};
        send_frame(-1, -1);
        model_frame();
        drain_and_compare("t5");
        chk_status("t5", 1'b1);
        cap_en = 1'b0;
        cyc(4);

        // 6: reset mid-line, then a clean frame must start with sof
        do_reset();
        cap_en = 1'b1;
        lens = '{6, 6, 6};
        send_frame(-1, 1);
        chk("t6_partial_rx", 32'(rx_q.size()), 32'd0);
        chk("t6_partial_frm", 32'(stu_frame_cnt), 32'd0);
        lens = '{4, 6};
        send_frame(-1, -1);
        model_frame();
        drain_and_compare("t6");
        chk_status("t6", 1'b1);
        cap_en = 1'b0;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
